commit_trace_buffer: RTL and testbench
======================================

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, sets FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter STOP_ON_FULL, default 0; when it is 1, an overflow SHALL halt capture until clear.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 update_i  input  1  commit strobe from core_model update_o; one retired instruction per high cycle.
REQ-006 pc_i  input  XLEN  PC of the committing instruction.
REQ-007 data_i  input  XLEN  data word of the committing instruction.
REQ-008 enable_i  input  1  capture enable; when low, commits SHALL be counted but not stored.
REQ-009 clear_i  input  1  synchronous clear of overflow, drop count and HALT state; FIFO contents are kept.
REQ-010 trc_valid_o  output  1  head entry available.
REQ-011 trc_ready_i  input  1  downstream accepts the head entry.
REQ-012 trc_pc_o, trc_data_o  output  XLEN each  head entry fields.
REQ-013 trc_seq_o  output  32  retirement sequence number of the head entry.
REQ-014 count_o  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 overflow_o  output  1  sticky flag, set when a commit is lost.
REQ-016 drop_cnt_o  output  16  number of lost commits, saturating at 16'hFFFF.
REQ-017 retired_o  output  32  total commits seen since reset, wrapping modulo 2^32.

Function
REQ-018 Each cycle with update_i=1, retired_o SHALL increment by 1, whatever the enable, halt or full state.
REQ-019 An entry {pc_i, data_i, seq=retired_o value before increment} SHALL be pushed when update_i & enable_i & state==RUN & space is available.
REQ-020 Space is available when count_o<DEPTH, or when count_o==DEPTH and a pop occurs in the same cycle.
REQ-021 A commit that qualifies for capture but has no space SHALL NOT be stored.
  - overflow_o set to 1.
  - drop_cnt_o incremented, saturating.
  - if STOP_ON_FULL=1, state goes RUN->HALT.
REQ-022 In HALT, qualifying commits SHALL be dropped and counted in drop_cnt_o; pops SHALL continue.
REQ-023 clear_i=1 SHALL force state to RUN and zero both overflow_o and drop_cnt_o on the next edge.
REQ-024 If clear_i and a drop occur in the same cycle, clear SHALL win.
REQ-025 Pop SHALL occur when trc_valid_o & trc_ready_i; the head advances on the next edge.
REQ-026 trc_valid_o SHALL equal (count_o!=0) and SHALL be registered; there is no combinational path from update_i to trc_valid_o.
REQ-027 Push-to-visible latency SHALL be 1 cycle: a push at edge N gives trc_valid_o=1 after edge N when the FIFO was empty.
REQ-028 Head fields SHALL be stable while trc_valid_o=1 and trc_ready_i=0.
REQ-029 On a simultaneous push and pop, count_o SHALL be unchanged and order SHALL be preserved (FIFO).
REQ-030 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-031 The state machine SHALL have two states, RUN and HALT; HALT is reachable only when STOP_ON_FULL=1.

Reset
REQ-032 While rst_i=1 at an edge, the block SHALL set:
  - state=RUN, pointers=0;
  - count_o=0, trc_valid_o=0;
  - overflow_o=0, drop_cnt_o=0, retired_o=0.
REQ-033 Reset SHALL take priority over update_i, clear_i and pop; in-flight entries are discarded.
REQ-034 trc_pc_o, trc_data_o and trc_seq_o are don't-care while trc_valid_o=0; storage RAM needs no reset.

Structure
REQ-035 riscv_pkg SHALL hold XLEN, the trace_entry_t struct {pc, data, seq} and the trc_state_e enum {RUN, HALT}.
REQ-036 A sub-module trace_fifo (parameterised by DEPTH and entry type, push/pop/full/empty/count) SHALL hold storage.
REQ-037 Capture control, the state machine and the counters SHALL live in commit_trace_buffer.

Verification
REQ-038 Reset, then 3 commits pc=0x0,0x4,0x8 with ready=1 -> three pops in order, seq 0,1,2, retired_o=3, overflow_o=0.
REQ-039 DEPTH=8, ready=0, 10 commits -> count_o=8, drop_cnt_o=2, overflow_o=1; pops then return seq 0..7.
REQ-040 FIFO full, STOP_ON_FULL=1, drain 8 entries then 2 more commits -> both dropped, drop_cnt_o=2 (plus the overflowing commit), state HALT; after clear_i, the next commit is stored.
REQ-041 FIFO full, then update_i and pop in the same cycle -> count_o stays 8, no drop, new entry at tail.
REQ-042 enable_i=0 with 5 commits -> retired_o=5, count_o=0; then enable_i=1 and 1 commit -> its seq=5.
REQ-043 Reset asserted with 4 entries queued -> next cycle count_o=0, trc_valid_o=0, retired_o=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the commit trace path: architectural width, trace entry layout
// and the capture state machine encoding.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int SEQ_W  = 32;
    localparam int DROP_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } trc_state_e;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  data;
        logic [SEQ_W-1:0] seq;
    } trace_entry_t;

    // Saturating increment used by the lost-commit counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
        return (value == {DROP_W{1'b1}}) ? value : value + DROP_W'(1);
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Valid/ready trace stream carrying the head entry of the commit trace buffer.
interface commit_trace_buffer_if;
    import riscv_pkg::*;

    logic             trc_valid_o;
    logic             trc_ready_i;
    logic [XLEN-1:0]  trc_pc_o;
    logic [XLEN-1:0]  trc_data_o;
    logic [SEQ_W-1:0] trc_seq_o;

    modport master (
        output trc_valid_o,
        output trc_pc_o,
        output trc_data_o,
        output trc_seq_o,
        input  trc_ready_i
    );

    modport slave (
        input  trc_valid_o,
        input  trc_pc_o,
        input  trc_data_o,
        input  trc_seq_o,
        output trc_ready_i
    );

endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO over an inferred RAM with a registered head read;
// the head register bypasses the RAM when the slot being exposed is written this cycle.
module trace_fifo #(
    parameter int  DEPTH = 8,
    parameter type entry_t = logic [31:0],
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  entry_t           din,
    output entry_t           dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           mem [DEPTH];
    entry_t           head_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop & ~empty_reg;
    assign push_ok = push & (~full_reg | pop_ok);

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Head register tracks the slot rd_ptr will point at after this edge.
    always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= din;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == CNT_W'(DEPTH));
            empty_reg  <= (count_next == '0);
        end
    end

    assign dout  = head_reg;
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = count_reg;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures retired instructions into a trace FIFO, counting every commit and
// accounting for those lost to a full buffer or a halted capture.
module commit_trace_buffer
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter bit  STOP_ON_FULL = 1'b0,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  update_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       data_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    commit_trace_buffer_if.master trc,
    output logic [CNT_W-1:0]      count_o,
    output logic                  overflow_o,
    output logic [DROP_W-1:0]     drop_cnt_o,
    output logic [SEQ_W-1:0]      retired_o
);

    trc_state_e        state_reg;
    trc_state_e        state_next;
    logic              capture_en;
    logic              qualify;
    logic              pop;
    logic              space;
    logic              push;
    logic              drop;
    logic              lost;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    trace_entry_t      push_entry;
    trace_entry_t      head_entry;
    logic              overflow_reg;
    logic [DROP_W-1:0] drop_cnt_reg;
    logic [SEQ_W-1:0]  retired_reg;

    assign qualify = update_i & enable_i;
    assign pop     = ~fifo_empty & trc.trc_ready_i;
    assign space   = ~fifo_full | pop;
    assign push    = qualify & capture_en & space;
    // Lost to a full FIFO while running; drop also covers commits refused in HALT.
    assign lost    = qualify & capture_en & ~space;
    assign drop    = qualify & ~push;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear_i) begin
            state_next = RUN;
        end else if (STOP_ON_FULL && (state_reg == RUN) && lost) begin
            state_next = HALT;
        end
    end

    always_comb begin
        capture_en = (state_reg == RUN);
    end

    always_comb begin
        push_entry      = '0;
        push_entry.pc   = pc_i;
        push_entry.data = data_i;
        push_entry.seq  = retired_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
            retired_reg  <= '0;
        end else begin
            retired_reg <= retired_reg + SEQ_W'(update_i);
            if (clear_i) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= '0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
                drop_cnt_reg <= sat_inc(drop_cnt_reg);
            end
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (trace_entry_t)
    ) u_fifo (
        .clk   (clk_i),
        .srst  (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign trc.trc_valid_o = ~fifo_empty;
    assign trc.trc_pc_o    = head_entry.pc;
    assign trc.trc_data_o  = head_entry.data;
    assign trc.trc_seq_o   = head_entry.seq;

    assign count_o    = fifo_count;
    assign overflow_o = overflow_reg;
    assign drop_cnt_o = drop_cnt_reg;
    assign retired_o  = retired_reg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Drives two buffers (STOP_ON_FULL 0 and 1) with shared stimulus and checks both
// against a queue-based model every cycle, plus directed scenario checkpoints.
module tb_commit_trace_buffer;
    import riscv_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        update = 1'b0;
    logic        enable = 1'b1;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] data = '0;

    always #5 clk = ~clk;

    commit_trace_buffer_if trc0 ();
    commit_trace_buffer_if trc1 ();
    assign trc0.trc_ready_i = ready;
    assign trc1.trc_ready_i = ready;

    logic [CNT_W-1:0] count0, count1;
    logic             overflow0, overflow1;
    logic [15:0]      drop0, drop1;
    logic [31:0]      retired0, retired1;

    commit_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .update_i(update), .pc_i(pc), .data_i(data),
        .enable_i(enable), .clear_i(clear), .trc(trc0), .count_o(count0),
        .overflow_o(overflow0), .drop_cnt_o(drop0), .retired_o(retired0)
    );

    commit_trace_buffer #(.DEPTH(DEPTH), .STOP_ON_FULL(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .update_i(update), .pc_i(pc), .data_i(data),
        .enable_i(enable), .clear_i(clear), .trc(trc1), .count_o(count1),
        .overflow_o(overflow1), .drop_cnt_o(drop1), .retired_o(retired1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    trace_entry_t mq [2][$];
    int unsigned  m_ret  [2];
    bit           m_ovf  [2];
    int unsigned  m_drop [2];
    bit           m_halt [2];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural reference: one call advances instance k by one clock edge.
    task automatic model_step(input int k);
        bit           pop_now;
        bit           space;
        trace_entry_t e;
        if (rst) begin
            mq[k].delete();
            m_ret[k] = 0; m_ovf[k] = 0; m_drop[k] = 0; m_halt[k] = 0;
            return;
        end
        pop_now = (mq[k].size() != 0) && ready;
        space   = (mq[k].size() < DEPTH) || pop_now;
        if (pop_now) void'(mq[k].pop_front());
        if (update && enable) begin
            if (!m_halt[k] && space) begin
                e.pc = pc; e.data = data; e.seq = m_ret[k];
                mq[k].push_back(e);
            end else begin
                m_ovf[k] = 1;
                if (m_drop[k] < 65535) m_drop[k]++;
                if (k == 1) m_halt[k] = 1;
            end
        end
        if (clear) begin
            m_halt[k] = 0; m_ovf[k] = 0; m_drop[k] = 0;
        end
        if (update) m_ret[k]++;
    endtask

    task automatic compare_dut(input int k, input logic [CNT_W-1:0] cnt, input logic valid,
                               input logic [31:0] hpc, input logic [31:0] hdata, input logic [31:0] hseq,
                               input logic ovf, input logic [15:0] drp, input logic [31:0] ret);
        check_value($sformatf("d%0d.count", k), 64'(cnt), 64'(mq[k].size()));
        check_value($sformatf("d%0d.valid", k), 64'(valid), 64'(mq[k].size() != 0));
        check_value($sformatf("d%0d.overflow", k), 64'(ovf), 64'(m_ovf[k]));
        check_value($sformatf("d%0d.drop_cnt", k), 64'(drp), 64'(m_drop[k]));
        check_value($sformatf("d%0d.retired", k), 64'(ret), 64'(m_ret[k]));
        if (mq[k].size() != 0) begin
            check_value($sformatf("d%0d.head_pc", k), 64'(hpc), 64'(mq[k][0].pc));
            check_value($sformatf("d%0d.head_data", k), 64'(hdata), 64'(mq[k][0].data));
            check_value($sformatf("d%0d.head_seq", k), 64'(hseq), 64'(mq[k][0].seq));
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_dut(0, count0, trc0.trc_valid_o, trc0.trc_pc_o, trc0.trc_data_o, trc0.trc_seq_o,
                    overflow0, drop0, retired0);
        compare_dut(1, count1, trc1.trc_valid_o, trc1.trc_pc_o, trc1.trc_data_o, trc1.trc_seq_o,
                    overflow1, drop1, retired1);
    endtask

    task automatic do_reset();
        rst = 1'b1; update = 1'b0; clear = 1'b0; ready = 1'b0; enable = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic commit(input logic [31:0] cpc);
        update = 1'b1; pc = cpc; data = $urandom;
        tick();
        update = 1'b0;
    endtask

    initial begin
        // Reset state and in-order drain of three commits.
        do_reset();
        check_value("reset.count", 64'(count0), 64'd0);
        check_value("reset.valid", 64'(trc0.trc_valid_o), 64'd0);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) commit(32'(i * 4));
        repeat (3) tick();
        check_value("s1.retired", 64'(retired0), 64'd3);
        check_value("s1.overflow", 64'(overflow0), 64'd0);
        check_value("s1.count", 64'(count0), 64'd0);

        // Overflow with ready low, then drain, halted drops, and clear.
        do_reset();
        for (int i = 0; i < 10; i++) commit(32'(32'h100 + i * 4));
        check_value("s2.count", 64'(count0), 64'd8);
        check_value("s2.drop", 64'(drop0), 64'd2);
        check_value("s2.overflow", 64'(overflow0), 64'd1);
        check_value("s2.halt_drop", 64'(drop1), 64'd2);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_value("s2.drain_seq", 64'(trc0.trc_seq_o), 64'(i));
            tick();
        end
        ready = 1'b0;
        commit(32'h200);
        commit(32'h204);
        check_value("s2.halt_count", 64'(count1), 64'd0);
        check_value("s2.halt_drop2", 64'(drop1), 64'd4);
        check_value("s2.run_count", 64'(count0), 64'd2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_value("s2.clear_drop", 64'(drop1), 64'd0);
        commit(32'h208);
        check_value("s2.after_clear", 64'(count1), 64'd1);

        // Full FIFO with simultaneous commit and pop.
        do_reset();
        for (int i = 0; i < 8; i++) commit(32'(i * 4));
        update = 1'b1; ready = 1'b1; pc = 32'h300; data = $urandom;
        tick();
        update = 1'b0; ready = 1'b0;
        check_value("s3.count", 64'(count0), 64'd8);
        check_value("s3.drop", 64'(drop0), 64'd0);
        check_value("s3.drop_halt", 64'(drop1), 64'd0);

        // Commits with capture disabled still advance the sequence.
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) commit(32'(i * 4));
        check_value("s4.retired", 64'(retired0), 64'd5);
        check_value("s4.count", 64'(count0), 64'd0);
        enable = 1'b1;
        commit(32'h400);
        check_value("s4.seq", 64'(trc0.trc_seq_o), 64'd5);

        // Reset discards queued entries.
        do_reset();
        for (int i = 0; i < 4; i++) commit(32'(i * 4));
        check_value("s5.count_pre", 64'(count0), 64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_value("s5.count", 64'(count0), 64'd0);
        check_value("s5.valid", 64'(trc0.trc_valid_o), 64'd0);
        check_value("s5.retired", 64'(retired0), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            update = ($urandom_range(0, 99) < 60);
            enable = ($urandom_range(0, 99) < 85);
            ready  = ($urandom_range(0, 99) < 45);
            clear  = ($urandom_range(0, 99) < 3);
            rst    = ($urandom_range(0, 999) < 5);
            pc     = $urandom;
            data   = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
